// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - master-side and IO-bus signal bundle for io_bus_arbiter
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr_data;
  logic [DATA_W-1:0] m0_rd_data;
  logic              m0_ack;
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr_data;
  logic [DATA_W-1:0] m1_rd_data;
  logic              m1_ack;
`ifdef ARB_LOCK_EN
  logic              m0_lock;
  logic              m1_lock;
`endif
  logic              bus_cs;
  logic              bus_wr;
  logic              bus_rd;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic [1:0]        grant;
  logic              busy;

  // Arbiter side: owns the IO bus strobes and the master acks
  modport master (
`ifdef ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    input  m0_req, m0_wr, m0_addr, m0_wr_data,
    input  m1_req, m1_wr, m1_addr, m1_wr_data,
    input  bus_rd_data,
    output m0_rd_data, m0_ack, m1_rd_data, m1_ack,
    output bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data,
    output grant, busy
  );

  // Environment side: requesting masters plus the IO slot returning read data
  modport slave (
`ifdef ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output m0_req, m0_wr, m0_addr, m0_wr_data,
    output m1_req, m1_wr, m1_addr, m1_wr_data,
    output bus_rd_data,
    input  m0_rd_data, m0_ack, m1_rd_data, m1_ack,
    input  bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data,
    input  grant, busy
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin IO bus arbiter; ARB_LOCK_EN adds master lock
module io_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIRST_PRIO = 0
) (
  input logic              clk,
  input logic              reset,
  io_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_nx;
  logic              owner, owner_d;
  logic              cur_wr, cur_wr_d;
  logic              last_winner, last_winner_d;
  logic [3:0]        cnt, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pick_valid, pick, capture;
`ifdef ARB_LOCK_EN
  logic              lock_hold, lock_hold_d, owner_lock;
`endif

  // Choose the next owner: lone requester wins, ties go to the master that did not win last
  always_comb begin
    pick_valid = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) pick = ~last_winner;
    else                          pick = bus.m1_req;
`ifdef ARB_LOCK_EN
    if (lock_hold && (owner ? bus.m1_req : bus.m0_req)) pick = owner;
`endif
  end

  // Next-state decode for the single in-flight transaction
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = ISSUE;
      ISSUE:   state_nx = (cur_wr || RD_LATENCY == 0) ? ACK : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of every registered output, derived from where the FSM is heading
  always_comb begin
    owner_d  = owner;
    cur_wr_d = cur_wr;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = (state_nx == IDLE) ? 2'b00 : grant_q;
    if (state == IDLE && pick_valid) begin
      owner_d  = pick;
      cur_wr_d = pick ? bus.m1_wr      : bus.m0_wr;
      addr_d   = pick ? bus.m1_addr    : bus.m0_addr;
      wdata_d  = pick ? bus.m1_wr_data : bus.m0_wr_data;
      grant_d  = pick ? 2'b10 : 2'b01;
    end
    cs_d    = (state_nx == ISSUE);
    wr_d    = cs_d & cur_wr_d;
    rd_d    = cs_d & ~cur_wr_d;
    busy_d  = (state_nx != IDLE);
    ack_d   = (state_nx == ACK) ? grant_q : 2'b00;
    cnt_d   = (state == ISSUE) ? 4'(RD_LATENCY) : (state == WAIT) ? cnt - 4'd1 : cnt;
    capture = (state == ISSUE && !cur_wr && RD_LATENCY == 0) || (state == WAIT && cnt == 4'd1);
    rdata0_d = (capture && !owner) ? bus.bus_rd_data : rdata0_q;
    rdata1_d = (capture &&  owner) ? bus.bus_rd_data : rdata1_q;
    last_winner_d = last_winner;
`ifdef ARB_LOCK_EN
    owner_lock  = owner ? bus.m1_lock : bus.m0_lock;
    lock_hold_d = lock_hold;
    if (state == ACK) begin
      lock_hold_d = owner_lock;
      if (!owner_lock) last_winner_d = owner;
    end else if (state == IDLE && !(owner ? bus.m1_req : bus.m0_req)) begin
      lock_hold_d = 1'b0;
    end
`else
    if (state == ACK) last_winner_d = owner;
`endif
  end

  // State and output registers; reset aborts any transfer without an ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cur_wr      <= 1'b0;
      last_winner <= (FIRST_PRIO == 0);
      cnt         <= 4'd0;
      grant_q     <= 2'b00;
      ack_q       <= 2'b00;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef ARB_LOCK_EN
      lock_hold   <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      owner       <= owner_d;
      cur_wr      <= cur_wr_d;
      last_winner <= last_winner_d;
      cnt         <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef ARB_LOCK_EN
      lock_hold   <= lock_hold_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.bus_cs      = cs_q;
  assign bus.bus_wr      = wr_q;
  assign bus.bus_rd      = rd_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;
  assign bus.m0_ack      = ack_q[0];
  assign bus.m1_ack      = ack_q[1];
  assign bus.m0_rd_data  = rdata0_q;
  assign bus.m1_rd_data  = rdata1_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed scoreboard bench for io_bus_arbiter
module tb_io_bus_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   ack_count;
  int   base;

  typedef struct {
    logic        m;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  io_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .FIRST_PRIO(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    chk("ack_exclusive", 32'(ifc.m0_ack & ifc.m1_ack), 32'd0);
    chk("strobe_when_idle", 32'((ifc.bus_cs | ifc.bus_wr | ifc.bus_rd) & ~ifc.busy), 32'd0);
    if (ifc.m0_ack || ifc.m1_ack) begin
      ack_count++;
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_master", 32'(ifc.m1_ack), 32'(e.m));
        if (e.rd) chk("sb_rd_data", e.m ? ifc.m1_rd_data : ifc.m0_rd_data, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(ifc.busy), 32'd0);
    chk({tag, "_grant"},  32'(ifc.grant), 32'd0);
    chk({tag, "_cs"},     32'(ifc.bus_cs), 32'd0);
    chk({tag, "_wr"},     32'(ifc.bus_wr), 32'd0);
    chk({tag, "_rd"},     32'(ifc.bus_rd), 32'd0);
    chk({tag, "_addr"},   ifc.bus_addr, 32'd0);
    chk({tag, "_wdata"},  ifc.bus_wr_data, 32'd0);
    chk({tag, "_m0_ack"}, 32'(ifc.m0_ack), 32'd0);
    chk({tag, "_m1_ack"}, 32'(ifc.m1_ack), 32'd0);
    chk({tag, "_m0_rd"},  ifc.m0_rd_data, 32'd0);
    chk({tag, "_m1_rd"},  ifc.m1_rd_data, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; ack_count = 0;
    reset = 1'b0;
    ifc.m0_req = 1'b0; ifc.m0_wr = 1'b0; ifc.m0_addr = '0; ifc.m0_wr_data = '0;
    ifc.m1_req = 1'b0; ifc.m1_wr = 1'b0; ifc.m1_addr = '0; ifc.m1_wr_data = '0;
    ifc.bus_rd_data = '0;
`ifdef ARB_LOCK_EN
    ifc.m0_lock = 1'b0; ifc.m1_lock = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Single m0 write
    ifc.m0_req = 1'b1; ifc.m0_wr = 1'b1; ifc.m0_addr = 32'hC000_0004; ifc.m0_wr_data = 32'h55;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    step();
    chk("wr_cs",    32'(ifc.bus_cs), 32'd1);
    chk("wr_wr",    32'(ifc.bus_wr), 32'd1);
    chk("wr_rd",    32'(ifc.bus_rd), 32'd0);
    chk("wr_addr",  ifc.bus_addr, 32'hC000_0004);
    chk("wr_data",  ifc.bus_wr_data, 32'h55);
    chk("wr_grant", 32'(ifc.grant), 32'd1);
    chk("wr_early_ack", 32'(ifc.m0_ack), 32'd0);
    step();
    chk("wr_ack",       32'(ifc.m0_ack), 32'd1);
    chk("wr_grant_ack", 32'(ifc.grant), 32'd1);
    chk("wr_cs_off",    32'(ifc.bus_cs), 32'd0);
    ifc.m0_req = 1'b0;
    step();
    chk("wr_idle_grant", 32'(ifc.grant), 32'd0);
    chk("wr_idle_busy",  32'(ifc.busy), 32'd0);
    chk("wr_ack_pulse",  32'(ifc.m0_ack), 32'd0);

    // m1 read, latency 1
    ifc.m1_req = 1'b1; ifc.m1_wr = 1'b0; ifc.m1_addr = 32'hC000_0010;
    sb.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
    step();
    chk("rd_cs",    32'(ifc.bus_cs), 32'd1);
    chk("rd_rd",    32'(ifc.bus_rd), 32'd1);
    chk("rd_wr",    32'(ifc.bus_wr), 32'd0);
    chk("rd_addr",  ifc.bus_addr, 32'hC000_0010);
    chk("rd_grant", 32'(ifc.grant), 32'd2);
    step();
    chk("rd_wait_ack",  32'(ifc.m1_ack), 32'd0);
    chk("rd_wait_cs",   32'(ifc.bus_cs), 32'd0);
    chk("rd_wait_busy", 32'(ifc.busy), 32'd1);
    ifc.bus_rd_data = 32'hDEAD_BEEF;
    step();
    chk("rd_ack",  32'(ifc.m1_ack), 32'd1);
    chk("rd_data", ifc.m1_rd_data, 32'hDEAD_BEEF);
    ifc.m1_req = 1'b0; ifc.bus_rd_data = 32'h0;
    step();

    // Contention from reset: both write continuously, grants alternate
    reset = 1'b0;
    ifc.m0_req = 1'b1; ifc.m0_wr = 1'b1; ifc.m0_addr = 32'hC000_0100; ifc.m0_wr_data = 32'h1;
    ifc.m1_req = 1'b1; ifc.m1_wr = 1'b1; ifc.m1_addr = 32'hC000_0200; ifc.m1_wr_data = 32'h2;
    step(); step();
    reset = 1'b1;
    base = ack_count;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    for (int i = 1; i <= 12; i++) step();
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    chk("cont_four_acks", 32'(ack_count - base), 32'd4);
    step(); step();
    chk("cont_idle", 32'(ifc.busy), 32'd0);

    // Abort an m0 read in WAIT
    ifc.m0_req = 1'b1; ifc.m0_wr = 1'b0; ifc.m0_addr = 32'hC000_0008;
    step();
    step();
    chk("abort_in_wait", 32'(ifc.busy), 32'd1);
    reset = 1'b0;
    ifc.m0_req = 1'b0;
    #1;
    chk_all_zero("abort");
    step(); step();
    reset = 1'b1;
    step();
    ifc.m1_req = 1'b1; ifc.m1_wr = 1'b0; ifc.m1_addr = 32'hC000_0020;
    sb.push_back('{1'b1, 1'b1, 32'h1234_5678});
    step();
    chk("post_abort_rd",   32'(ifc.bus_rd), 32'd1);
    chk("post_abort_addr", ifc.bus_addr, 32'hC000_0020);
    step();
    ifc.bus_rd_data = 32'h1234_5678;
    step();
    chk("post_abort_ack",  32'(ifc.m1_ack), 32'd1);
    chk("post_abort_data", ifc.m1_rd_data, 32'h1234_5678);
    ifc.m1_req = 1'b0; ifc.bus_rd_data = 32'h0;
    step();

    // m1 drops req and changes addr right after grant
    base = ack_count;
    ifc.m1_req = 1'b1; ifc.m1_wr = 1'b1; ifc.m1_addr = 32'hC000_0030; ifc.m1_wr_data = 32'hAA;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    step();
    chk("drop_cs",    32'(ifc.bus_wr & ifc.bus_cs), 32'd1);
    chk("drop_addr",  ifc.bus_addr, 32'hC000_0030);
    chk("drop_grant", 32'(ifc.grant), 32'd2);
    ifc.m1_req = 1'b0; ifc.m1_addr = 32'hFFFF_0000; ifc.m1_wr_data = 32'h0;
    step();
    chk("drop_ack",       32'(ifc.m1_ack), 32'd1);
    chk("drop_addr_held", ifc.bus_addr, 32'hC000_0030);
    chk("drop_wdata",     ifc.bus_wr_data, 32'hAA);
    step();
    chk("drop_ack_once", 32'(ifc.m1_ack), 32'd0);
    chk("rd_hold_on_wr", ifc.m1_rd_data, 32'h1234_5678);
    step(); step();
    chk("drop_one_ack", 32'(ack_count - base), 32'd1);

`ifdef ARB_LOCK_EN
    // m0 holds lock: three consecutive m0 grants, then m1 once lock drops
    reset = 1'b0;
    ifc.m0_lock = 1'b1;
    ifc.m0_req = 1'b1; ifc.m0_wr = 1'b1;
    ifc.m1_req = 1'b1; ifc.m1_wr = 1'b1;
    step(); step();
    reset = 1'b1;
    base = ack_count;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b0, 1'b0, 32'h0});
    sb.push_back('{1'b1, 1'b0, 32'h0});
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 7) ifc.m0_lock = 1'b0;
    end
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    chk("lock_four_acks", 32'(ack_count - base), 32'd4);
`endif

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Two-master arbiter in front of the IO slot controller. Shares the single IO bus (cs/wr/rd/addr/wr_data/rd_data) between the CPU load/store port (master 0) and a DMA engine (master 1).
- Round-robin grant, one transaction in flight at a time.
- Per-master req/ack handshake; the read return is sampled after a fixed latency.

Parameters:
- ADDR_W, 32, bus and master address width
- DATA_W, 32, data width
- RD_LATENCY, 1, cycles from strobe cycle to bus_rd_data valid (legal 0..15)
- FIRST_PRIO, 0, master that wins the first tie after reset (0 or 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 transaction request; held until m0_ack
- m0_wr  in  1  1=write, 0=read
- m0_addr  in  ADDR_W  master 0 address
- m0_wr_data  in  DATA_W  master 0 write data
- m0_rd_data  out  DATA_W  master 0 read data, valid with m0_ack
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_rd_data, m1_ack  same as m0_* for master 1
- bus_cs  out  1  IO bus chip select
- bus_wr  out  1  write strobe
- bus_rd  out  1  read strobe
- bus_addr  out  ADDR_W  IO bus address
- bus_wr_data  out  DATA_W  IO bus write data
- bus_rd_data  in  DATA_W  IO bus read data
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; last-winner register = ~FIRST_PRIO; latency counter = 0.
- All bus_* and m*_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Only one req high: grant that master.
  - Both req high: grant the master that is not last-winner.
  - On grant: latch addr/wr/wr_data into bus_addr/bus_wr_data, set grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - bus_cs=1, plus bus_wr=wr or bus_rd=~wr.
  - Write: go to ACK.
  - Read, RD_LATENCY=0: capture bus_rd_data this cycle, go to ACK.
  - Read, RD_LATENCY>0: load counter=RD_LATENCY, go to WAIT.
- WAIT:
  - Strobes 0; bus_addr held.
  - Counter decrements each cycle.
  - Capture bus_rd_data into the granted master's rd_data in the cycle the counter reaches 1, then go to ACK.
- ACK (1 cycle):
  - Granted master's ack=1; update last-winner.
  - Next state IDLE; grant clears on entry to IDLE.
- Latency, req sampled in IDLE at cycle N:
  - Strobe at N+1.
  - Write ack at N+2.
  - Read ack at N+2+RD_LATENCY.
  - Next arbitration in the IDLE cycle after ack, so back-to-back transactions from one master are 3 cycles apart (writes).
- m*_rd_data holds its last captured value until the next read for that master. It is not cleared on writes.
- Master-side changes after grant:
  - req dropped after grant: transaction still completes and ack still pulses.
  - addr/data changes after grant are ignored (latched copy used).
- A req rising while the other master is being served waits; no request is dropped.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. No ack is issued for the aborted transfer.
- bus_cs/bus_wr/bus_rd are never high together with busy=0. At most one strobe is high per transaction.

Optional Feature:
- Macro ARB_LOCK_EN adds inputs m0_lock and m1_lock (1 bit each).
- With the macro:
  - If the granted master has lock=1 during its ACK cycle, the next IDLE grants that master if its req is high, regardless of round-robin.
  - last-winner is not updated for a locked ack.
  - Lock is ignored once that master's req is low in IDLE.
- Without the macro: no lock ports; pure round-robin.

Test Plan:
- Single write: m0 write addr=0xC000_0004, data=0x55; m1 idle.
  - bus_cs=bus_wr=1 for exactly one cycle at N+1 with that addr/data.
  - m0_ack at N+2; grant=01 from N+1 to N+2.
- Read latency: RD_LATENCY=1, m1 read addr 0xC000_0010, bus_rd_data=0xDEADBEEF in cycle N+2.
  - m1_rd_data=0xDEADBEEF together with m1_ack at N+3.
- Contention: m0 and m1 both request writes continuously from reset, FIRST_PRIO=0.
  - Grants alternate m0, m1, m0, m1.
  - Four acks within 12 cycles; never both acks in the same cycle.
- Abort: assert reset during WAIT of an m0 read.
  - All outputs 0 next sample, no m0_ack.
  - After release, a fresh m1 read completes normally.
- Req drop: m1 deasserts req the cycle after grant.
  - Strobe still issues; m1_ack still pulses once.
- ARB_LOCK_EN: m0 holds lock=1 with req continuous while m1 also requests.
  - m0 granted three times consecutively.
  - When m0 drops lock, the next grant goes to m1.
